// File: rtl/interrupt_unit_pkg.sv
// Shared types and default constants for the interrupt/reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package interrupt_unit_pkg;

  // Kind of sequence the control unit is asked to run; encoding is visible on int_kind.
  typedef enum logic [1:0] {
    IntNone  = 2'b00,
    IntReset = 2'b01,
    IntNmi   = 2'b10,
    IntIrq   = 2'b11
  } int_kind_t;

  typedef enum logic [1:0] {
    IntIdle    = 2'b00,
    IntPending = 2'b01,
    IntService = 2'b10
  } int_state_t;

  // Address bus source selections owned by the interrupt unit during vector fetch.
  typedef enum logic [0:0] {
    AddressLowSrcCore      = 1'b0,
    AddressLowSrcIntVector = 1'b1
  } address_low_src_t;

  typedef enum logic [0:0] {
    AddressHighSrcCore      = 1'b0,
    AddressHighSrcIntVector = 1'b1
  } address_high_src_t;

  localparam logic [15:0] DEFAULT_RES_VECTOR      = 16'hFFFC;
  localparam logic [15:0] DEFAULT_NMI_VECTOR      = 16'hFFFA;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR      = 16'hFFFE;
  localparam logic [15:0] DEFAULT_IRQ_VECTOR_BASE = 16'hFFE0;

  // Vectors are even, so the high-byte read address is low byte + 1 with no carry.
  function automatic logic [7:0] vector_low_byte(input logic [15:0] vec, input logic hi_sel);
    return vec[7:0] + {7'b0, hi_sel};
  endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// Request/vector handshake between the interrupt unit and the 6502 control unit.
// Latency: n/a (wiring only).
// Backpressure: request held until int_ack; vector held until vector_done.
// Ports: master = control unit side (drives lines, ack, hi_sel, done);
//        slave  = interrupt unit (drives request, kind, source, vector bytes, busy).
interface interrupt_unit_if #(
  parameter int NUM_IRQ = 4
);
  import interrupt_unit_pkg::*;

  logic               nmi_n;
  logic [NUM_IRQ-1:0] irq_n;
  logic               flag_irq_disable;
  logic               fetch_boundary;
  logic               int_ack;
  logic               vector_hi_sel;
  logic               vector_done;
  logic               int_request;
  int_kind_t          int_kind;
  logic [2:0]         irq_source;
  logic [7:0]         vector_addr_low;
  logic [7:0]         vector_addr_high;
  logic               busy;

  modport master (
    output nmi_n, irq_n, flag_irq_disable, fetch_boundary, int_ack, vector_hi_sel, vector_done,
    input  int_request, int_kind, irq_source, vector_addr_low, vector_addr_high, busy
  );

  modport slave (
    input  nmi_n, irq_n, flag_irq_disable, fetch_boundary, int_ack, vector_hi_sel, vector_done,
    output int_request, int_kind, irq_source, vector_addr_low, vector_addr_high, busy
  );
endinterface

// File: rtl/interrupt_unit_priority_encoder.sv
// Lowest-index-wins priority encoder over WIDTH request bits (WIDTH 1..8).
// Latency: combinational.
// Backpressure: none.
// Ports: req (active-high requests), index (winning bit), valid (any request).
module interrupt_unit_priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [2:0]       index,
  output logic             valid
);

  always_comb begin
    index = '0;
    valid = |req;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_unit.sv
// RESET/NMI/IRQ sequencer: arbitrates at fetch boundaries, presents kind + vector bytes.
// Latency: boundary -> int_request 1 cycle; int_ack -> busy 1 cycle; vector bytes combinational.
// Backpressure: request held in PENDING until int_ack; vector held in SERVICE until vector_done.
// Ports: clk_in, reset (sync, active-high); bus (interrupt_unit_if.slave) carries nmi_n, irq_n,
//        flag_irq_disable, fetch_boundary, int_ack, vector_hi_sel, vector_done in and
//        int_request, int_kind, irq_source, vector_addr_low/high, busy out.
// Build option: define INT_VECTORED_IRQ_EN to give each IRQ source its own vector at
//               IRQ_VECTOR_BASE + 2*i; otherwise all IRQs share IRQ_VECTOR.
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] RES_VECTOR = DEFAULT_RES_VECTOR,
  parameter logic [15:0] NMI_VECTOR = DEFAULT_NMI_VECTOR,
  parameter logic [15:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
`ifdef INT_VECTORED_IRQ_EN
  , parameter logic [15:0] IRQ_VECTOR_BASE = DEFAULT_IRQ_VECTOR_BASE
`endif
) (
  input  logic           clk_in,
  input  logic           reset,
  interrupt_unit_if.slave bus
);

  int_state_t  state_q, state_d;
  int_kind_t   kind_q, kind_d;
  logic [2:0]  src_q, src_d;
  logic        nmi_prev;
  logic        nmi_latched;
  logic        nmi_edge;
  logic        nmi_ack;
  logic [2:0]  enc_index;
  logic        enc_valid;
  logic        irq_pending;
  logic [15:0] vector;

  interrupt_unit_priority_encoder #(.WIDTH(NUM_IRQ)) u_prio (
    .req   (~bus.irq_n),
    .index (enc_index),
    .valid (enc_valid)
  );

  assign irq_pending = enc_valid & ~bus.flag_irq_disable;
  assign nmi_edge    = nmi_prev & ~bus.nmi_n;
  assign nmi_ack     = (state_q == IntPending) && bus.int_ack && (kind_q == IntNmi);

  // NMI edge capture. A fresh edge wins over the clearing ack so an NMI
  // arriving in the acknowledge cycle is kept for the next boundary.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      nmi_prev    <= 1'b1;
      nmi_latched <= 1'b0;
    end else begin
      nmi_prev <= bus.nmi_n;
      if (nmi_edge)     nmi_latched <= 1'b1;
      else if (nmi_ack) nmi_latched <= 1'b0;
    end
  end

  // Reset lands directly in PENDING/RESET so the core always runs the reset sequence first.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IntPending;
      kind_q  <= IntReset;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    src_d   = src_q;
    unique case (state_q)
      IntIdle: begin
        if (bus.fetch_boundary && (nmi_latched || irq_pending)) begin
          state_d = IntPending;
          if (nmi_latched) begin
            kind_d = IntNmi;
            src_d  = '0;
          end else begin
            kind_d = IntIrq;
            src_d  = enc_index;
          end
        end
      end
      IntPending: if (bus.int_ack)     state_d = IntService;
      IntService: if (bus.vector_done) state_d = IntIdle;
      default:    state_d = IntIdle;
    endcase
  end

  // Vector comes from the frozen kind/source so a dropped IRQ line cannot change it mid-fetch.
  always_comb begin
    vector = RES_VECTOR;
    case (kind_q)
      IntNmi: vector = NMI_VECTOR;
`ifdef INT_VECTORED_IRQ_EN
      IntIrq: vector = IRQ_VECTOR_BASE + {12'b0, src_q, 1'b0};
`else
      IntIrq: vector = IRQ_VECTOR;
`endif
      default: vector = RES_VECTOR;
    endcase
  end

  assign bus.int_request      = (state_q == IntPending);
  assign bus.busy             = (state_q == IntService);
  assign bus.int_kind         = (state_q == IntIdle) ? IntNone : kind_q;
  assign bus.irq_source       = src_q;
  assign bus.vector_addr_low  = vector_low_byte(vector, bus.vector_hi_sel);
  assign bus.vector_addr_high = vector[15:8];

endmodule

// File: tb/tb_interrupt_unit.sv
module tb_interrupt_unit;
  import interrupt_unit_pkg::*;

`ifdef INT_VECTORED_IRQ_EN
  localparam logic [7:0] IRQ0_LO = 8'hE0;
  localparam logic [7:0] IRQ2_LO = 8'hE4;
`else
  localparam logic [7:0] IRQ0_LO = 8'hFE;
  localparam logic [7:0] IRQ2_LO = 8'hFE;
`endif

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_in = ~clk_in;

  interrupt_unit_if #(.NUM_IRQ(4)) bus ();

  interrupt_unit #(.NUM_IRQ(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ack_seq();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask

  task automatic done_seq();
    bus.vector_done = 1'b1; step(); bus.vector_done = 1'b0;
  endtask

  task automatic boundary();
    bus.fetch_boundary = 1'b1; step(); bus.fetch_boundary = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (bus.int_request !== 1'b1) begin bad++; $display("FAIL rst_req got %b want 1", bus.int_request); end
    total++; if (bus.int_kind !== 2'b01) begin bad++; $display("FAIL rst_kind got %b want 01", bus.int_kind); end
    total++; if (bus.busy !== 1'b0 || bus.irq_source !== 3'd0) begin bad++; $display("FAIL rst_busy_src got %b/%0d want 0/0", bus.busy, bus.irq_source); end
    reset = 1'b0;
    step();
    total++; if (bus.int_request !== 1'b1) begin bad++; $display("FAIL rst_hold got %b want 1", bus.int_request); end
    ack_seq();
    total++; if (bus.busy !== 1'b1 || bus.int_request !== 1'b0) begin bad++; $display("FAIL rst_svc busy/req got %b/%b want 1/0", bus.busy, bus.int_request); end
    bus.vector_hi_sel = 1'b0; #1;
    total++; if ({bus.vector_addr_high, bus.vector_addr_low} !== 16'hFFFC) begin bad++; $display("FAIL rst_vec_lo got %h%h want FFFC", bus.vector_addr_high, bus.vector_addr_low); end
    bus.vector_hi_sel = 1'b1; #1;
    total++; if ({bus.vector_addr_high, bus.vector_addr_low} !== 16'hFFFD) begin bad++; $display("FAIL rst_vec_hi got %h%h want FFFD", bus.vector_addr_high, bus.vector_addr_low); end
    bus.vector_hi_sel = 1'b0;
    done_seq();
    total++; if (bus.int_request !== 1'b0 || bus.busy !== 1'b0 || bus.int_kind !== 2'b00) begin bad++; $display("FAIL rst_idle req/busy/kind got %b/%b/%b want 0/0/00", bus.int_request, bus.busy, bus.int_kind); end
  endtask

  task automatic test_nmi();
    bus.nmi_n = 1'b0; step();          // edge seen, latched on this clock
    boundary();
    total++; if (bus.int_request !== 1'b1 || bus.int_kind !== 2'b10) begin bad++; $display("FAIL nmi_req req/kind got %b/%b want 1/10", bus.int_request, bus.int_kind); end
    ack_seq();
    total++; if ({bus.vector_addr_high, bus.vector_addr_low} !== 16'hFFFA) begin bad++; $display("FAIL nmi_vec_lo got %h%h want FFFA", bus.vector_addr_high, bus.vector_addr_low); end
    bus.vector_hi_sel = 1'b1; #1;
    total++; if ({bus.vector_addr_high, bus.vector_addr_low} !== 16'hFFFB) begin bad++; $display("FAIL nmi_vec_hi got %h%h want FFFB", bus.vector_addr_high, bus.vector_addr_low); end
    bus.vector_hi_sel = 1'b0;
    done_seq();
    boundary(); boundary(); boundary();  // nmi_n still low: level must not retrigger
    total++; if (bus.int_request !== 1'b0) begin bad++; $display("FAIL nmi_level got %b want 0", bus.int_request); end
    bus.nmi_n = 1'b1; step();
  endtask

  task automatic test_irq();
    bus.irq_n = 4'b1010; bus.flag_irq_disable = 1'b0;
    boundary();
    total++; if (bus.int_kind !== 2'b11 || bus.irq_source !== 3'd0) begin bad++; $display("FAIL irq_kind_src got %b/%0d want 11/0", bus.int_kind, bus.irq_source); end
    ack_seq();
    total++; if ({bus.vector_addr_high, bus.vector_addr_low} !== {8'hFF, IRQ0_LO}) begin bad++; $display("FAIL irq_vec got %h%h want FF%h", bus.vector_addr_high, bus.vector_addr_low, IRQ0_LO); end
    bus.vector_hi_sel = 1'b1; #1;
    total++; if (bus.vector_addr_low !== IRQ0_LO + 8'd1) begin bad++; $display("FAIL irq_vec_hi got %h want %h", bus.vector_addr_low, IRQ0_LO + 8'd1); end
    bus.vector_hi_sel = 1'b0;
    bus.irq_n = 4'hF;
    done_seq();
  endtask

  task automatic test_irq_masked();
    bus.irq_n = 4'b1011; bus.flag_irq_disable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      boundary();
      total++; if (bus.int_request !== 1'b0) begin bad++; $display("FAIL irq_masked_%0d got %b want 0", i, bus.int_request); end
    end
    bus.flag_irq_disable = 1'b0;
    boundary();
    total++; if (bus.int_request !== 1'b1 || bus.irq_source !== 3'd2) begin bad++; $display("FAIL irq_unmask req/src got %b/%0d want 1/2", bus.int_request, bus.irq_source); end
    bus.irq_n = 4'hF; step();          // line dropped while pending: phantom IRQ still runs
    ack_seq();
    total++; if (bus.busy !== 1'b1 || bus.irq_source !== 3'd2 || bus.vector_addr_low !== IRQ2_LO) begin bad++; $display("FAIL irq_phantom busy/src/lo got %b/%0d/%h want 1/2/%h", bus.busy, bus.irq_source, bus.vector_addr_low, IRQ2_LO); end
    done_seq();
  endtask

  task automatic test_nmi_and_irq();
    bus.irq_n = 4'b1110;
    bus.nmi_n = 1'b0; step();
    boundary();
    total++; if (bus.int_kind !== 2'b10) begin bad++; $display("FAIL both_first got %b want 10", bus.int_kind); end
    ack_seq(); done_seq();
    boundary();
    total++; if (bus.int_kind !== 2'b11 || bus.irq_source !== 3'd0) begin bad++; $display("FAIL both_second got %b/%0d want 11/0", bus.int_kind, bus.irq_source); end
    bus.irq_n = 4'hF;
    ack_seq(); done_seq();
    bus.nmi_n = 1'b1; step();
  endtask

  task automatic test_back_to_back();
    bus.nmi_n = 1'b0; step();
    boundary();
    bus.nmi_n = 1'b1; step();
    bus.nmi_n = 1'b0;                  // new edge in the same cycle as the NMI ack
    ack_seq();
    done_seq();
    boundary();
    total++; if (bus.int_request !== 1'b1 || bus.int_kind !== 2'b10) begin bad++; $display("FAIL b2b_nmi req/kind got %b/%b want 1/10", bus.int_request, bus.int_kind); end
    ack_seq(); done_seq();
    bus.nmi_n = 1'b1; step();
  endtask

  task automatic test_reset_mid();
    bus.irq_n = 4'b0111;
    boundary();
    total++; if (bus.irq_source !== 3'd3) begin bad++; $display("FAIL mid_src got %0d want 3", bus.irq_source); end
    ack_seq();
    bus.irq_n = 4'hF;
    bus.nmi_n = 1'b0; step();          // NMI latched while in SERVICE
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    reset = 1'b1; bus.nmi_n = 1'b1; step();
    total++; if (bus.int_request !== 1'b1 || bus.int_kind !== 2'b01 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset req/kind/busy got %b/%b/%b want 1/01/0", bus.int_request, bus.int_kind, bus.busy); end
    reset = 1'b0;
    ack_seq(); done_seq();
    boundary(); boundary();
    total++; if (bus.int_request !== 1'b0) begin bad++; $display("FAIL mid_nmi_dropped got %b want 0", bus.int_request); end
  endtask

  initial begin
    bus.nmi_n = 1'b1; bus.irq_n = 4'hF; bus.flag_irq_disable = 1'b0;
    bus.fetch_boundary = 1'b0; bus.int_ack = 1'b0; bus.vector_hi_sel = 1'b0; bus.vector_done = 1'b0;
    test_reset();
    test_nmi();
    test_irq();
    test_irq_masked();
    test_nmi_and_irq();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
Name: interrupt_unit

Overview:
- Parametrised interrupt/reset sequencer for the 6502 core.
- Collects one NMI line and NUM_IRQ level-sensitive IRQ lines, arbitrates them at instruction boundaries and hands the control unit a request plus the 16-bit vector address.
- Generalises the core's fixed reset-only entry to RESET/NMI/IRQ with a handshake.
- Drives the address-low and address-high bus sources during vector fetch.

Parameters:
- NUM_IRQ, 4, number of maskable IRQ sources (1..8).
- RES_VECTOR, 16'hFFFC, reset vector address.
- NMI_VECTOR, 16'hFFFA, NMI vector address.
- IRQ_VECTOR, 16'hFFFE, shared IRQ vector address.
- IRQ_VECTOR_BASE, 16'hFFE0, base for per-source vectors (optional feature only).

Ports:
- clk_in  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- nmi_n  input  1  NMI, active-low, falling-edge triggered.
- irq_n  input  NUM_IRQ  IRQ lines, active-low, level-sensitive.
- flag_irq_disable  input  1  I flag from the status register.
- fetch_boundary  input  1  control unit is at an opcode-fetch cycle.
- int_ack  input  1  control unit accepts the request (1-cycle pulse).
- vector_hi_sel  input  1  0 = present low vector byte, 1 = present high byte.
- vector_done  input  1  control unit finished both vector reads (1-cycle pulse).
- int_request  output  1  an interrupt/reset sequence is pending.
- int_kind  output  2  00 none, 01 RESET, 10 NMI, 11 IRQ.
- irq_source  output  3  index of the serviced IRQ line.
- vector_addr_low  output  8  address-low bus source.
- vector_addr_high  output  8  address-high bus source.
- busy  output  1  in SERVICE state.

Behaviour:
- Reset values:
  - State = PENDING with kind RESET, so the first sequence after reset is always RESET.
  - int_request=1, int_kind=01, irq_source=0, busy=0.
  - nmi_latched=0; nmi edge register = 1.
  - Vector outputs = RES_VECTOR bytes per vector_hi_sel.
- NMI edge detect:
  - nmi_n is registered once; a falling edge (prev=1, now=0) sets nmi_latched on the next clock.
  - nmi_latched clears only on int_ack when NMI is the kind being acknowledged.
  - An edge arriving in the same cycle as that ack is preserved, not lost.
- IRQ: irq_pending = |(~irq_n) & ~flag_irq_disable; not latched. The line must be held until serviced.
- Priority: RESET > NMI > IRQ; among IRQs the lowest index wins.
- State machine:
  - IDLE: if fetch_boundary and (nmi_latched or irq_pending), go to PENDING. Kind and source are frozen on this transition.
  - PENDING: int_request=1, int_kind valid. On int_ack, go to SERVICE.
  - SERVICE: busy=1, int_request=0. Vector bytes are driven combinationally from the frozen kind. On vector_done, go to IDLE.
  - int_ack outside PENDING and vector_done outside SERVICE are ignored.
- Vector outputs: vector_addr_low is always the low byte of the selected vector. vector_addr_high is the high byte. vector_hi_sel=1 adds 1 to the low byte, giving FFFD/FFFF/FFFB; there is no carry because vectors are even.
- Latency: NMI edge to int_request is at most 2 cycles after the next fetch_boundary. int_ack to busy is 1 cycle.
- IRQ deasserted while in PENDING: the request still completes with the frozen source (phantom IRQ; software handles it).
- NMI during SERVICE: latched and taken at the next boundary after IDLE.
- Reset mid-sequence: returns to PENDING/RESET on the next edge; any latched NMI is discarded.

Optional Feature:
- INT_VECTORED_IRQ_EN.
- Defined: each IRQ source i uses vector IRQ_VECTOR_BASE + 2*i. NMI and RESET vectors are unchanged.
- Undefined: all IRQs share IRQ_VECTOR. irq_source is still reported so firmware can poll it.

Decomposition:
- Add to control_signals package:
  - int_kind_t enum (IntNone, IntReset, IntNmi, IntIrq).
  - int_state_t enum (IntIdle, IntPending, IntService).
  - Default vector constants.
- Add to bus_sources: AddressLowSrcIntVector and AddressHighSrcIntVector entries.
- Sub-module priority_encoder (NUM_IRQ wide, outputs index and valid): natural and reusable.

Test Plan:
- Reset 2 cycles, release:
  - Expect int_request=1, kind=01.
  - Ack, then vector_hi_sel 0/1 gives low/high bytes FC/FF then FD/FF.
  - vector_done leads to IDLE with int_request=0.
- nmi_n 1→0 held low, fetch_boundary pulse:
  - Expect PENDING kind=10 and vector FFFA/FFFB.
  - Holding nmi_n low triggers no second request.
- irq_n=4'b1010, flag_irq_disable=0, boundary:
  - Expect kind=11, irq_source=0.
  - With INT_VECTORED_IRQ_EN, vector FFE0; without, FFFE.
- irq_n=4'b1011 with flag_irq_disable=1, boundaries repeated: expect no request. Clearing the flag gives a request with source 2.
- NMI edge and IRQ both active at the same boundary: NMI is serviced first; IRQ is serviced at the next boundary after vector_done.
- Reset asserted in SERVICE with nmi_latched=1: expect PENDING/RESET next cycle, and no NMI request afterwards.
